// File: rtl/curl_pow_driver_if.sv
// Host-side bus bundle for curl_pow_driver.
// Carries the job control inputs, the input word stream, the nonce output
// stream, the job status outputs and the Curl PoW core word interface.
// master : driver view (drives o_*, samples i_*)
// slave  : environment view (drives i_*, samples o_*)
interface curl_pow_driver_if #(
    parameter int unsigned DATA_WIDTH    = 54,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned BLK_CNT_WIDTH = 16
);
    // job control
    logic                     i_start;
    logic [BLK_CNT_WIDTH-1:0] i_num_blocks;
    logic [5:0]               i_mwm;
    // input word stream
    logic                     i_in_valid;
    logic [DATA_WIDTH-1:0]    i_in_data;
    logic                     o_in_ready;
    // nonce output stream
    logic                     o_out_valid;
    logic [DATA_WIDTH-1:0]    o_out_data;
    logic                     o_out_last;
    logic                     i_out_ready;
    // status
    logic                     o_busy;
    logic                     o_done;
    logic [31:0]              o_attempts;
    // core word interface
    logic                     o_core_we;
    logic [ADDR_WIDTH-1:0]    o_core_addr;
    logic [DATA_WIDTH-1:0]    o_core_data;
    logic                     o_core_transform;
    logic                     o_core_pow;
    logic [31:0]              o_core_mwm_mask;
    logic                     i_core_transforming;
    logic                     i_core_pow_hash_finish;
    logic                     i_core_pow_finish;
    logic [DATA_WIDTH-1:0]    i_core_data;

    modport master (
        input  i_start, i_num_blocks, i_mwm, i_in_valid, i_in_data, i_out_ready,
               i_core_transforming, i_core_pow_hash_finish, i_core_pow_finish, i_core_data,
        output o_in_ready, o_out_valid, o_out_data, o_out_last, o_busy, o_done, o_attempts,
               o_core_we, o_core_addr, o_core_data, o_core_transform, o_core_pow, o_core_mwm_mask
    );

    modport slave (
        output i_start, i_num_blocks, i_mwm, i_in_valid, i_in_data, i_out_ready,
               i_core_transforming, i_core_pow_hash_finish, i_core_pow_finish, i_core_data,
        input  o_in_ready, o_out_valid, o_out_data, o_out_last, o_busy, o_done, o_attempts,
               o_core_we, o_core_addr, o_core_data, o_core_transform, o_core_pow, o_core_mwm_mask
    );
endinterface

// File: rtl/curl_pow_driver.sv
// Curl PoW job sequencer.
// Streams 9-word blocks of a job into the core, kicks a transform after every
// block but the last, kicks PoW after the last block, counts hash attempts and
// returns the 3 nonce words on an output stream.
// Ports:
//   i_clk  : clock
//   i_arst : asynchronous reset, active-high (abandons any job in flight)
//   bus    : curl_pow_driver_if.master (job control, in/out streams, status,
//            core word interface)
module curl_pow_driver #(
    parameter int unsigned DATA_WIDTH    = 54,
    parameter int unsigned BLOCK_WORDS   = 9,
    parameter int unsigned NONCE_WORDS   = 3,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned BLK_CNT_WIDTH = 16
) (
    input  logic i_clk,
    input  logic i_arst,
    curl_pow_driver_if.master bus
);

    localparam int unsigned RD_W = $clog2(NONCE_WORDS + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(BLOCK_WORDS - 1);
    localparam logic [RD_W-1:0]       NONCE_CNT  = RD_W'(NONCE_WORDS);
    localparam logic [RD_W-1:0]       LAST_NONCE = RD_W'(NONCE_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_TF_KICK,
        S_TF_GUARD,
        S_TF_WAIT,
        S_POW_KICK,
        S_POW_WAIT,
        S_READ,
        S_DONE
    } state_e;

    state_e                   state_q;
    logic [BLK_CNT_WIDTH-1:0] blocks_left_q;
    logic [ADDR_WIDTH-1:0]    word_cnt_q;
    logic [RD_W-1:0]          rd_idx_q;
    logic [31:0]              attempts_q;
    logic [31:0]              mask_q;
    logic [DATA_WIDTH-1:0]    out_data_q;
    logic                     out_valid_q;
    logic                     out_last_q;

    logic [5:0]               mwm_d;
    logic [31:0]              mask_d;
    logic                     in_fire;
    logic                     out_fire;
    logic                     fetch;

    // Mask is fixed for the whole job, so it is computed once at start.
    assign mwm_d  = (bus.i_mwm > 6'd32) ? 6'd32 : bus.i_mwm;
    assign mask_d = ~(32'hFFFF_FFFF >> mwm_d);

    assign in_fire  = (state_q == S_LOAD) && bus.i_in_valid;
    assign out_fire = out_valid_q && bus.i_out_ready;
    // rd_idx_q addresses the next word to fetch; a word is fetched when the
    // output register is empty or being emptied this cycle, which lets
    // consecutive nonce words stream back-to-back.
    assign fetch    = (state_q == S_READ) && (rd_idx_q < NONCE_CNT) &&
                      (!out_valid_q || bus.i_out_ready);

    always_comb begin
        bus.o_core_we   = 1'b0;
        bus.o_core_addr = '0;
        bus.o_core_data = '0;
        if (state_q == S_LOAD) begin
            bus.o_core_we   = in_fire;
            bus.o_core_addr = word_cnt_q;
            bus.o_core_data = bus.i_in_data;
        end else if (state_q == S_READ) begin
            bus.o_core_addr = ADDR_WIDTH'(rd_idx_q);
        end
    end

    assign bus.o_in_ready       = (state_q == S_LOAD);
    assign bus.o_core_transform = (state_q == S_TF_KICK);
    assign bus.o_core_pow       = (state_q == S_POW_KICK);
    assign bus.o_busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.o_done           = (state_q == S_DONE);
    assign bus.o_attempts       = attempts_q;
    assign bus.o_core_mwm_mask  = mask_q;
    assign bus.o_out_valid      = out_valid_q;
    assign bus.o_out_data       = out_data_q;
    assign bus.o_out_last       = out_last_q;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q       <= S_IDLE;
            blocks_left_q <= '0;
            word_cnt_q    <= '0;
            rd_idx_q      <= '0;
            attempts_q    <= '0;
            mask_q        <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        blocks_left_q <= (bus.i_num_blocks == '0) ? BLK_CNT_WIDTH'(1)
                                                                  : bus.i_num_blocks;
                        mask_q        <= mask_d;
                        attempts_q    <= '0;
                        word_cnt_q    <= '0;
                        rd_idx_q      <= '0;
                        state_q       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (word_cnt_q == LAST_WORD) begin
                            word_cnt_q <= '0;
                            state_q    <= (blocks_left_q > BLK_CNT_WIDTH'(1)) ? S_TF_KICK
                                                                              : S_POW_KICK;
                        end else begin
                            word_cnt_q <= word_cnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                S_TF_KICK: begin
                    blocks_left_q <= blocks_left_q - BLK_CNT_WIDTH'(1);
                    state_q       <= S_TF_GUARD;
                end
                // One idle cycle so the core's registered busy flag is visible.
                S_TF_GUARD: state_q <= S_TF_WAIT;
                S_TF_WAIT: begin
                    if (!bus.i_core_transforming) state_q <= S_LOAD;
                end
                S_POW_KICK: state_q <= S_POW_WAIT;
                S_POW_WAIT: begin
                    if (bus.i_core_pow_hash_finish && (attempts_q != '1)) begin
                        attempts_q <= attempts_q + 32'd1;
                    end
                    if (bus.i_core_pow_finish) begin
                        rd_idx_q <= '0;
                        state_q  <= S_READ;
                    end
                end
                S_READ: begin
                    if (fetch) begin
                        out_data_q  <= bus.i_core_data;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_idx_q == LAST_NONCE);
                        rd_idx_q    <= rd_idx_q + RD_W'(1);
                    end else if (out_fire && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_curl_pow_driver.sv
module tb_curl_pow_driver;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    curl_pow_driver_if #(.DATA_WIDTH(54), .ADDR_WIDTH(4), .BLK_CNT_WIDTH(16)) ifc ();

    curl_pow_driver #(
        .DATA_WIDTH(54),
        .BLOCK_WORDS(9),
        .NONCE_WORDS(3),
        .ADDR_WIDTH(4),
        .BLK_CNT_WIDTH(16)
    ) dut (
        .i_clk (clk),
        .i_arst(arst),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // core model state
    logic [53:0] nonce [3];
    logic [53:0] exp_wr [$];
    int  tf_cycles = 81;
    int  hash_n    = 1;
    bit  coincide  = 0;
    bit  stall_mode = 0;
    int  tf_left = 0, hleft = 0, since_tf = 99, stall_cnt = 0;
    bit  pow_active = 0;
    bit  prev_wait = 0;
    logic [53:0] prev_data;
    int  wr_cnt, wr_bad, wr_viol, tf_pulses, pow_pulses, both_viol, done_cnt;
    int  out_cnt, out_bad, last_bad, stall_bad, in_to;

    always_comb begin
        ifc.i_core_data = '0;
        if (ifc.o_core_addr < 4'd3) ifc.i_core_data = nonce[ifc.o_core_addr[1:0]];
    end

    task automatic clear_counts();
        wr_cnt = 0; wr_bad = 0; wr_viol = 0; tf_pulses = 0; pow_pulses = 0;
        both_viol = 0; done_cnt = 0; out_cnt = 0; out_bad = 0; last_bad = 0;
        stall_bad = 0; in_to = 0;
    endtask

    // Core + downstream model: observe at negedge, drive at posedge+1.
    initial begin
        ifc.i_core_transforming    = 1'b0;
        ifc.i_core_pow_hash_finish = 1'b0;
        ifc.i_core_pow_finish      = 1'b0;
        ifc.i_out_ready            = 1'b1;
        clear_counts();
        forever begin
            @(negedge clk);
            if (ifc.o_core_we) begin
                if (wr_cnt < exp_wr.size()) begin
                    if (ifc.o_core_addr !== 4'(wr_cnt % 9) || ifc.o_core_data !== exp_wr[wr_cnt])
                        wr_bad++;
                end else wr_bad++;
                if (ifc.i_core_transforming || since_tf < 2) wr_viol++;
                wr_cnt++;
            end
            if (ifc.o_core_transform && ifc.o_core_pow) both_viol++;
            if (ifc.o_core_transform) begin
                tf_pulses++; tf_left = tf_cycles; since_tf = 0;
            end else if (since_tf < 99) since_tf++;
            if (ifc.o_core_pow) begin
                pow_pulses++; pow_active = 1; hleft = hash_n;
            end
            if (ifc.o_done) done_cnt++;
            if (ifc.o_out_valid) begin
                if (prev_wait && ifc.o_out_data !== prev_data) stall_bad++;
                if (ifc.i_out_ready) begin
                    if (out_cnt < 3) begin
                        if (ifc.o_out_data !== nonce[out_cnt]) out_bad++;
                        if (ifc.o_out_last !== (out_cnt == 2)) last_bad++;
                    end else out_bad++;
                    out_cnt++;
                    prev_wait = 0;
                end else begin
                    prev_wait = 1; prev_data = ifc.o_out_data;
                end
            end else begin
                if (prev_wait && !arst) stall_bad++;
                prev_wait = 0;
            end
            @(posedge clk);
            #1;
            ifc.i_core_pow_hash_finish = 1'b0;
            ifc.i_core_pow_finish      = 1'b0;
            if (arst) begin
                tf_left = 0; pow_active = 0; prev_wait = 0; stall_cnt = 0;
                ifc.i_core_transforming = 1'b0;
                ifc.i_out_ready = !stall_mode;
            end else begin
                ifc.i_core_transforming = (tf_left > 0);
                if (tf_left > 0) tf_left--;
                if (pow_active) begin
                    if (hleft > 0) begin
                        ifc.i_core_pow_hash_finish = 1'b1;
                        hleft--;
                        if (hleft == 0 && coincide) begin
                            ifc.i_core_pow_finish = 1'b1; pow_active = 0;
                        end
                    end else begin
                        ifc.i_core_pow_finish = 1'b1; pow_active = 0;
                    end
                end
                if (!stall_mode) ifc.i_out_ready = 1'b1;
                else if (ifc.i_out_ready) ifc.i_out_ready = 1'b0;
                else if (prev_wait) begin
                    stall_cnt++;
                    if (stall_cnt >= 5) begin ifc.i_out_ready = 1'b1; stall_cnt = 0; end
                end
            end
        end
    end

    task automatic start_job(input int nb, input int mwm);
        ifc.i_num_blocks = 16'(nb);
        ifc.i_mwm        = 6'(mwm);
        ifc.i_start      = 1'b1;
        @(posedge clk); #1;
        ifc.i_start      = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            bit got;
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 3));
                ifc.i_in_valid = 1'b0;
                repeat (g) begin @(posedge clk); #1; end
            end
            ifc.i_in_valid = 1'b1;
            ifc.i_in_data  = exp_wr[i];
            got = 0;
            for (int t = 0; t < 400 && !got; t++) begin
                @(negedge clk);
                got = ifc.o_in_ready;
                @(posedge clk); #1;
            end
            if (!got) in_to++;
        end
        ifc.i_in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit midstart);
        for (int c = 0; c < 20000 && done_cnt == 0; c++) begin
            @(posedge clk); #1;
            if (midstart && c == 50) begin
                ifc.i_num_blocks = 16'd7; ifc.i_start = 1'b1;
            end else ifc.i_start = 1'b0;
        end
        ifc.i_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic prep_job(input int job, input int nb, input int hn, input bit coin, input bit stall);
        int nbe;
        clear_counts();
        hash_n = hn; coincide = coin; stall_mode = stall;
        nbe = (nb == 0) ? 1 : nb;
        exp_wr.delete();
        for (int k = 0; k < 9 * nbe; k++) exp_wr.push_back(54'(job * 256 + k + 1));
        for (int i = 0; i < 3; i++) nonce[i] = 54'h2A_0000_0000_0000 + 54'(job * 16 + i * 3 + 5);
    endtask

    task automatic run_job(input string tag, input int job, input int nb, input int mwm,
                           input logic [31:0] exp_mask, input int hn, input bit coin,
                           input bit gaps, input bit stall, input bit midstart);
        int nbe;
        nbe = (nb == 0) ? 1 : nb;
        prep_job(job, nb, hn, coin, stall);
        start_job(nb, mwm);
        check({tag, "_busy"}, ifc.o_busy, 1);
        send_words(9 * nbe, gaps);
        wait_done(midstart);
        check({tag, "_in_timeout"}, in_to, 0);
        check({tag, "_writes"}, wr_cnt, 9 * nbe);
        check({tag, "_wr_data"}, wr_bad, 0);
        check({tag, "_wr_busy"}, wr_viol, 0);
        check({tag, "_tf_pulses"}, tf_pulses, nbe - 1);
        check({tag, "_pow_pulses"}, pow_pulses, 1);
        check({tag, "_kick_overlap"}, both_viol, 0);
        check({tag, "_mask"}, ifc.o_core_mwm_mask, exp_mask);
        check({tag, "_out_words"}, out_cnt, 3);
        check({tag, "_out_data"}, out_bad, 0);
        check({tag, "_out_last"}, last_bad, 0);
        check({tag, "_out_stable"}, stall_bad, 0);
        check({tag, "_attempts"}, ifc.o_attempts, hn);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_idle"}, ifc.o_busy, 0);
    endtask

    initial begin
        ifc.i_start = 1'b0; ifc.i_num_blocks = '0; ifc.i_mwm = '0;
        ifc.i_in_valid = 1'b0; ifc.i_in_data = '0;
        for (int i = 0; i < 3; i++) nonce[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", ifc.o_busy, 0);
        check("rst_attempts", ifc.o_attempts, 0);
        check("rst_mask", ifc.o_core_mwm_mask, 0);
        check("rst_in_ready", ifc.o_in_ready, 0);
        check("rst_out_valid", ifc.o_out_valid, 0);
        arst = 1'b0;
        @(posedge clk); #1;

        run_job("j1_basic",   0, 1,  0, 32'h0000_0000,    1, 0, 0, 0, 0);
        run_job("j2_3blk",    1, 3,  9, 32'hFF80_0000,    3, 0, 0, 0, 0);
        run_job("j3_mwm40",   2, 1, 40, 32'hFFFF_FFFF,    2, 0, 0, 0, 0);
        run_job("j4_stall",   3, 2, 32, 32'hFFFF_FFFF,    4, 0, 1, 1, 0);
        run_job("j5_1000",    4, 1, 13, 32'hFFF8_0000, 1000, 0, 0, 0, 1);
        run_job("j6_coinc",   5, 0,  1, 32'h8000_0000, 1000, 1, 0, 0, 0);

        // reset during POW_WAIT
        prep_job(6, 1, 1000, 0, 0);
        start_job(1, 20);
        send_words(9, 0);
        repeat (30) begin @(posedge clk); #1; end
        check("arst_pre_attempts_nz", (ifc.o_attempts != 0), 1);
        arst = 1'b1;
        #1;
        check("arst_busy", ifc.o_busy, 0);
        check("arst_attempts", ifc.o_attempts, 0);
        check("arst_mask", ifc.o_core_mwm_mask, 0);
        check("arst_pow", ifc.o_core_pow, 0);
        check("arst_out_valid", ifc.o_out_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        arst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("arst_no_out", out_cnt, 0);
        check("arst_no_done", done_cnt, 0);
        run_job("j7_after_rst", 7, 1, 20, 32'hFFFF_F000, 2, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
